// File: rtl/shift_seq_pkg.sv
// Shared types and grant encodings for the shift_seq sequencer and its arbiter.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_TX   = 2'b01;
    localparam logic [1:0] GNT_RX   = 2'b10;

endpackage

// File: rtl/shift_seq_rr_arb2.sv
// Two-requester round-robin tie-breaker; remembers the last winner so a tie
// goes to the other side. The FSM strobes update on the cycle it accepts a grant.
module rr_arb2
    import shift_seq_pkg::*;
(
    input  logic       clk_2,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic [1:0] last_grant;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        gnt = GNT_NONE;
        case (req)
            2'b01:   gnt = GNT_TX;
            2'b10:   gnt = GNT_RX;
            2'b11:   gnt = (last_grant == GNT_TX) ? GNT_RX : GNT_TX;
            default: gnt = GNT_NONE;
        endcase
    end

    // Starting from rx makes tx win the first tie after reset.
    always_ff @(posedge clk_2) begin
        if (!reset)
            last_grant <= GNT_RX;
        else if (update)
            last_grant <= gnt;
    end

endmodule

// File: rtl/shift_seq.sv
// Load/shift sequencer owning the NBITS-bit shift register, arbitrating tx and rx.
// Optional feature: define SHIFT_SEQ_PAUSE_EN to add a pause input that stalls SHIFT.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int NBITS = 4
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             tx_req,
    input  logic [NBITS-1:0] tx_data,
    output logic             tx_ack,
    input  logic             rx_req,
    output logic             rx_ack,
    output logic [NBITS-1:0] rx_data,
    input  logic             serial_in,
    output logic             serial_out,
    output logic             busy,
    output logic [1:0]       grant,
    output state_t           state
`ifdef SHIFT_SEQ_PAUSE_EN
    ,
    input  logic             pause
`endif
);

    localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    logic [NBITS-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic [NBITS-1:0] shifted;
    logic [1:0]       arb_gnt;
    logic             arb_update;
    logic             shift_en;

`ifdef SHIFT_SEQ_PAUSE_EN
    assign shift_en = !pause;
`else
    assign shift_en = 1'b1;
`endif

    assign shifted    = {serial_in, sr[NBITS-1:1]};
    assign serial_out = sr[0];
    assign arb_update = (state == S_IDLE) && (arb_gnt != GNT_NONE);

    rr_arb2 u_arb (
        .clk_2  (clk_2),
        .reset  (reset),
        .req    ({rx_req, tx_req}),
        .update (arb_update),
        .gnt    (arb_gnt)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_2) begin
        if (!reset) begin
            state   <= S_IDLE;
            sr      <= '0;
            cnt     <= '0;
            rx_data <= '0;
            tx_ack  <= 1'b0;
            rx_ack  <= 1'b0;
            busy    <= 1'b0;
            grant   <= GNT_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_gnt != GNT_NONE) begin
                        state <= S_LOAD;
                        grant <= arb_gnt;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    sr    <= (grant == GNT_TX) ? tx_data : '0;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (shift_en) begin
                        sr <= shifted;
                        if (cnt == CNT_W'(NBITS - 1)) begin
                            cnt   <= '0;
                            state <= S_DONE;
                            // Capture the post-shift word so the final serial_in bit is included.
                            if (grant == GNT_RX) begin
                                rx_data <= shifted;
                                rx_ack  <= 1'b1;
                            end else begin
                                tx_ack  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    tx_ack <= 1'b0;
                    rx_ack <= 1'b0;
                    busy   <= 1'b0;
                    grant  <= GNT_NONE;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq; inputs change and outputs are sampled on the falling edge.
module tb_shift_seq;
    import shift_seq_pkg::*;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b0;
    logic       tx_req = 1'b0;
    logic [3:0] tx_data = '0;
    logic       tx_ack;
    logic       rx_req = 1'b0;
    logic       rx_ack;
    logic [3:0] rx_data;
    logic       serial_in = 1'b0;
    logic       serial_out;
    logic       busy;
    logic [1:0] grant;
    state_t     state;
`ifdef SHIFT_SEQ_PAUSE_EN
    logic       pause = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_2 = ~clk_2;

    shift_seq #(.NBITS(4)) dut (
        .clk_2      (clk_2),
        .reset      (reset),
        .tx_req     (tx_req),
        .tx_data    (tx_data),
        .tx_ack     (tx_ack),
        .rx_req     (rx_req),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .serial_in  (serial_in),
        .serial_out (serial_out),
        .busy       (busy),
        .grant      (grant),
        .state      (state)
`ifdef SHIFT_SEQ_PAUSE_EN
        ,
        .pause      (pause)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_2);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tx_req = 1'b0;
        rx_req = 1'b0;
        serial_in = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 50) begin
            tick(1);
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(n < 50), 32'd1);
    endtask

    // Cycle k counts falling edges after the IDLE cycle in which the request is raised.
    task automatic run_tx(input string tag, input logic [3:0] data, input bit drop_in_load);
        tx_data = data;
        tx_req  = 1'b1;
        tick(1);
        check({tag, "_load_state"}, 32'(state), 32'(S_LOAD));
        check({tag, "_load_busy"}, 32'(busy), 32'd1);
        if (drop_in_load) tx_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check($sformatf("%s_bit%0d", tag, i), 32'(serial_out), 32'(data[i]));
            check($sformatf("%s_gnt%0d", tag, i), 32'(grant), 32'(GNT_TX));
            check($sformatf("%s_noack%0d", tag, i), 32'(tx_ack), 32'd0);
        end
        tick(1);
        check({tag, "_ack"}, 32'(tx_ack), 32'd1);
        check({tag, "_done_state"}, 32'(state), 32'(S_DONE));
        tx_req = 1'b0;
        tick(1);
        check({tag, "_ack_off"}, 32'(tx_ack), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_state"}, 32'(state), 32'(S_IDLE));
    endtask

    initial begin
        logic [3:0] rx_bits;
        logic       seen_ack;

        do_reset();
        check("rst_state", 32'(state), 32'(S_IDLE));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'(GNT_NONE));
        check("rst_acks", 32'({tx_ack, rx_ack}), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_serial_out", 32'(serial_out), 32'd0);
        tick(1);

        run_tx("tx1011", 4'b1011, 1'b0);

        // Receive 0,1,1,0 in SHIFT cycles 0..3.
        rx_bits = 4'b0110;
        rx_req  = 1'b1;
        tick(1);
        check("rx_gnt", 32'(grant), 32'(GNT_RX));
        for (int i = 0; i < 4; i++) begin
            tick(1);
            serial_in = rx_bits[i];
        end
        tick(1);
        check("rx_ack", 32'(rx_ack), 32'd1);
        check("rx_data", 32'(rx_data), 32'h6);
        rx_req    = 1'b0;
        serial_in = 1'b0;
        tick(1);
        check("rx_ack_off", 32'(rx_ack), 32'd0);
        tick(3);
        check("rx_data_hold", 32'(rx_data), 32'h6);

        run_tx("txdrop", 4'b0101, 1'b1);

        // Reset during SHIFT cycle 2 aborts without an ack.
        tx_data = 4'b1011;
        tx_req  = 1'b1;
        tick(4);
        check("abort_pre_state", 32'(state), 32'(S_SHIFT));
        reset  = 1'b0;
        tx_req = 1'b0;
        tick(1);
        check("abort_state", 32'(state), 32'(S_IDLE));
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_grant", 32'(grant), 32'(GNT_NONE));
        reset = 1'b1;
        seen_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            seen_ack |= tx_ack | rx_ack;
        end
        check("abort_no_ack", 32'(seen_ack), 32'd0);
        run_tx("post_abort", 4'b0110, 1'b0);

        // Both requests held from reset: tx, rx, tx, seven cycles apart.
        do_reset();
        tick(1);
        tx_req = 1'b1;
        rx_req = 1'b1;
        tick(1);
        check("tie1_gnt", 32'(grant), 32'(GNT_TX));
        tick(5);
        check("tie1_ack", 32'({rx_ack, tx_ack}), 32'b01);
        tick(2);
        check("tie2_gnt", 32'(grant), 32'(GNT_RX));
        tick(5);
        check("tie2_ack", 32'({rx_ack, tx_ack}), 32'b10);
        tick(2);
        check("tie3_gnt", 32'(grant), 32'(GNT_TX));
        tx_req = 1'b0;
        rx_req = 1'b0;
        wait_idle("tie");

`ifdef SHIFT_SEQ_PAUSE_EN
        begin
            logic [6:0] exp_out;
            exp_out = 7'b1011111; // cycles 2..8, bit 0 first: 1,1,1,1,1,0,1
            tx_data = 4'b1011;
            tx_req  = 1'b1;
            tick(1);
            for (int k = 2; k <= 8; k++) begin
                tick(1);
                if (k == 3) pause = 1'b1;
                if (k == 6) pause = 1'b0;
                check($sformatf("pause_out_c%0d", k), 32'(serial_out), 32'(exp_out[k-2]));
                check($sformatf("pause_noack_c%0d", k), 32'(tx_ack), 32'd0);
            end
            tick(1);
            check("pause_ack_c9", 32'(tx_ack), 32'd1);
            tx_req = 1'b0;
            wait_idle("pause");
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
